// File: rtl/debounce_pkg.sv
// Shared constants for the input debounce/synchronizer block.
// Edge pulses are built only when INPUT_DEBOUNCE_EDGE_EN is defined.
package debounce_pkg;

  localparam int unsigned DEBOUNCE_STABLE_DEFAULT = 4;
  localparam int unsigned DEBOUNCE_STABLE_MAX     = 255;

  function automatic int unsigned debounce_cnt_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Reset loads both stages with RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/input_debounce_sync.sv
// Synchronize and debounce a pad level; optional edge pulses.
// Macro INPUT_DEBOUNCE_EDGE_EN enables rise_pulse/fall_pulse.
module input_debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_STABLE_DEFAULT,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  output logic in_clean,
  output logic busy,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CW = debounce_cnt_w(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  generate
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > DEBOUNCE_STABLE_MAX) begin : g_bad
      $error("STABLE_CYCLES out of range 1..255");
    end
  endgenerate

  logic          s2;
  logic [CW-1:0] cnt;
  logic          flip;

  sync_2ff #(
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_raw),
    .q     (s2)
  );

  assign flip = (s2 != in_clean) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_clean <= RESET_VAL;
      cnt      <= '0;
    end else if (s2 == in_clean) begin
      cnt <= '0;
    end else if (flip) begin
      in_clean <= ~in_clean;
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign busy = (cnt != '0);

`ifdef INPUT_DEBOUNCE_EDGE_EN
  // Pulses line up with the cycle in_clean first shows its new value
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= flip & ~in_clean;
      fall_pulse <= flip &  in_clean;
    end
  end
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: doc/input_debounce_sync.md
INPUT_DEBOUNCE_SYNC -- requirements
Module: input_debounce_sync

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive mismatching cycles needed to accept a new level; legal range 1..255.
REQ-002 SHALL have parameter RESET_VAL, default 1'b0: value of in_clean after reset.
REQ-003 SHALL have port clk, input, 1: single clock for all state.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset sampled on posedge clk.
REQ-005 SHALL have port in_raw, input, 1: asynchronous, possibly bouncing level from the pad.
REQ-006 SHALL have port in_clean, output, 1: registered, debounced level that drives the downstream FSM "in" input.
REQ-007 SHALL have port busy, output, 1: high while a candidate level change is being qualified.
REQ-008 SHALL have port rise_pulse, output, 1: one-cycle pulse on an accepted 0->1 change of in_clean.
REQ-009 SHALL have port fall_pulse, output, 1: one-cycle pulse on an accepted 1->0 change of in_clean.

Function
REQ-010 SHALL pass in_raw through a two-flop synchronizer (s1, s2); only s2 feeds the qualification logic.
REQ-011 SHALL hold a counter cnt of width max(1, $clog2(STABLE_CYCLES)).
REQ-012 SHALL clear cnt on any edge where s2 == in_clean.
REQ-013 SHALL increment cnt on an edge where s2 != in_clean and cnt < STABLE_CYCLES-1.
REQ-014 SHALL invert in_clean and clear cnt on an edge where s2 != in_clean and cnt == STABLE_CYCLES-1.
REQ-015 SHALL give a latency of STABLE_CYCLES+2 posedges from a steady in_raw change (set up before edge 0) to the new in_clean value (visible after edge STABLE_CYCLES+1).
REQ-016 SHALL treat any glitch that returns s2 to in_clean before qualification completes as rejected: cnt clears and in_clean is unchanged.
REQ-017 SHALL flip in_clean on the first mismatching edge when STABLE_CYCLES == 1; the counter never increments in that case.
REQ-018 SHALL drive busy = (cnt != 0) combinationally from the registered cnt.
REQ-019 SHALL register rise_pulse and fall_pulse so each is high for exactly the one cycle in which in_clean first shows its new value, and they are never both high.
REQ-020 SHALL never let cnt wrap; its maximum value is STABLE_CYCLES-1.

Reset
REQ-021 SHALL, on reset, set s1 = s2 = in_clean = RESET_VAL, cnt = 0, busy = 0, rise_pulse = 0 and fall_pulse = 0.
REQ-022 SHALL have reset take priority over all other updates; reset asserted mid-qualification discards the pending change.
REQ-023 SHALL compare against RESET_VAL again from the first edge after reset deasserts (a held opposite level needs the full REQ-015 latency).

Configuration
REQ-024 SHALL generate rise_pulse and fall_pulse per REQ-019 when macro INPUT_DEBOUNCE_EDGE_EN is defined.
REQ-025 SHALL, when INPUT_DEBOUNCE_EDGE_EN is not defined, keep the ports, tie rise_pulse and fall_pulse to constant 0, and create no edge registers.

Structure
REQ-026 SHALL place DEBOUNCE_STABLE_DEFAULT (4) and DEBOUNCE_STABLE_MAX (255) in shared package debounce_pkg.
REQ-027 SHALL implement the two-flop synchronizer as sub-module sync_2ff (clk, reset, d, q, with parameter RESET_VAL).
REQ-028 SHALL flag STABLE_CYCLES outside 1..255 at elaboration.

Verification (STABLE_CYCLES=4, RESET_VAL=0, macro defined)
REQ-029 SHALL cover: reset held 3 cycles with in_raw=1 -> in_clean=0, busy=0 and pulses=0 during reset; in_clean=1 six edges after release.
REQ-030 SHALL cover: in_raw 0->1 held steady -> in_clean=1 after edge 5, rise_pulse high for that single cycle, busy high after edges 2-4.
REQ-031 SHALL cover: in_raw bounce 1,0,1,0 (one cycle each) then 0 -> in_clean stays 0, rise_pulse never asserts, cnt returns to 0.
REQ-032 SHALL cover: in_raw high for 3 synchronized cycles then low -> no change (one short of qualification).
REQ-033 SHALL cover: reset asserted when cnt=2 -> cnt=0 and in_clean=0 on the next edge; no pulse.
REQ-034 SHALL cover: build without the macro, with in_clean toggling -> rise_pulse=fall_pulse=0 throughout and in_clean timing identical to REQ-030.
